expr_arbiter: RTL and testbench
===============================

# expr_arbiter

Shares one serial ASCII expression evaluator (one character per clock: digits joined by `+`/`*`, `out` = current string valid, `res` = running result) between two requesters, A and B.
- Each requester submits a `=`-terminated expression over a valid/ready byte handshake.
- The block buffers the expression, streams it to the evaluator on back-to-back clocks with the evaluator's clear released, and reports verdict and result per expression.
- It sits between the character sources and the evaluator, and owns the evaluator's clear and input.

## Interface
- MAX_LEN, 16: maximum stored characters per expression, excluding `=`.
- RES_LAT, 2: cycles after the last streamed character at which `ev_res` is sampled; must be ≥1.
- clk  in  1  single clock; all state changes on rising edge.
- clr_n  in  1  reset, asynchronous, active-low.
- a_valid / a_char / a_ready  in / in / out  1 / 8 / 1  requester A byte handshake; transfer when valid&ready.
- b_valid / b_char / b_ready  in / in / out  1 / 8 / 1  requester B, same rules.
- ev_clr  out  1  evaluator clear, active-high.
- ev_in  out  8  character presented to evaluator.
- ev_out  in  1  evaluator valid flag, registered in evaluator.
- ev_res  in  8  evaluator result, ASCII.
- done  out  1  one-cycle completion pulse.
- done_id  out  1  0 = A, 1 = B; valid with done.
- done_ok  out  1  expression accepted.
- done_err  out  1  overflow, i.e. more than MAX_LEN characters before `=`.
- done_res  out  8  sampled `ev_res`; 8'h30 when not ok.
- busy  out  1  state ≠ IDLE.

## Operation
- States:
  - IDLE
  - LOAD
  - DRAIN
  - STREAM
  - WAIT
  - REPORT
- Reset (clr_n low, any time): state=IDLE, pointers=0, last_grant=B, done/done_ok/done_err/done_id=0, done_res=8'h30, ev_in=8'h20, a_ready=b_ready=0. Buffer contents are don't-care. No done is issued for an aborted expression.
- `ev_clr`=1 in IDLE, LOAD, DRAIN, REPORT; `ev_clr`=0 in STREAM and WAIT. `ev_in`=8'h20 outside STREAM.
- IDLE → LOAD when any valid is high.
  - Grant goes to the sole requester, or, if both are valid, per the arbitration policy (Configuration). The grant is latched until REPORT.
- LOAD: ready=1 for the granted requester only; the other requester's ready=0 and its valid is ignored.
  - Each transferred non-`=` char is written at wr_ptr, then wr_ptr++.
  - `=` transferred → STREAM if wr_ptr>0; else → REPORT with ok=0, err=0.
  - Non-`=` transfer when wr_ptr==MAX_LEN → DRAIN. The char is discarded.
- DRAIN: ready=1 to the granted requester; chars are discarded until `=` is transferred → REPORT with ok=0, err=1.
- STREAM: `ev_in`=buf[rd_ptr] for wr_ptr consecutive cycles, rd_ptr++ each cycle → WAIT. Both readys=0.
- WAIT: RES_LAT cycles.
  - `ev_out` is captured in the first WAIT cycle as ok.
  - `ev_res` is captured in the last WAIT cycle if ok; otherwise done_res=8'h30.
- REPORT: done=1 for one cycle with id/ok/err/res. Then last_grant := grant, pointers cleared, → IDLE.
- Chars other than `=` are stored verbatim; syntax judgement belongs to the evaluator.

## Timing
- `=` transferred at edge t, with L stored chars: STREAM spans cycles t+1..t+L and WAIT spans t+L+1..t+L+RES_LAT. done is high in cycle t+L+RES_LAT+1.
- Ready is registered. It deasserts in the cycle after `=` transfers, so at most one char per edge.
- Minimum gap between two grants: one IDLE cycle after REPORT.
- done_* hold their value until the next done. done itself is a pulse.

## Configuration
- `EXPR_ARB_RR_EN` defined: round-robin. On a tie, the requester ≠ last_grant wins.
- Undefined: fixed priority. A always wins a tie; last_grant is unused.

## Structure
- Shared package `expr_pkg`:
  - state enum
  - ASCII constants `CH_EQ`=8'h3D, `CH_SP`=8'h20, `CH_ZERO`=8'h30
  - requester ID encoding (ID_A=0, ID_B=1)
- Sub-module `expr_buf`: MAX_LEN×8 register file with synchronous write (wr_en, wr_ptr) and combinational read at rd_ptr. No reset on storage.

## Test plan
- A sends "1+2=" → ev_in='1','+','2' on 3 consecutive cycles with ev_clr=0; done with done_id=0, done_ok=1, done_err=0.
- A "3=" and B "4*5=" both valid in the same cycle after reset → with RR_EN: A served first, then B. Two done pulses, ids 0 then 1, both ok=1. Without RR_EN, repeated ties always serve A first.
- A sends "1+=" → done_ok=0, done_res=8'h30, done_err=0.
- B sends "=" only → no STREAM cycle (ev_clr stays 1); done 1 cycle later, ok=0, err=0, id=1.
- MAX_LEN=4, A sends "1+2+3=" → chars 5–6 drained. done_err=1, ok=0, no STREAM.
- clr_n driven low mid-STREAM → same cycle: ev_clr=1, busy=0, both readys 0; no done pulse. Next expression "7=" completes normally with ok=1.

Source files
------------

// File: rtl/expr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : expr_pkg
// Purpose  : Shared types and constants for the expression arbiter slice.
// Revision : 1.0 - initial release
// ============================================================================
package expr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_STREAM = 3'd3,
        ST_WAIT   = 3'd4,
        ST_REPORT = 3'd5
    } state_t;

    localparam logic [7:0] CH_EQ   = 8'h3D;
    localparam logic [7:0] CH_SP   = 8'h20;
    localparam logic [7:0] CH_ZERO = 8'h30;

    localparam logic ID_A = 1'b0;
    localparam logic ID_B = 1'b1;

endpackage
`default_nettype wire

// File: rtl/expr_buf.sv
`default_nettype none
// ============================================================================
// Module   : expr_buf
// Purpose  : Expression character store, sync write / combinational read.
// Revision : 1.0 - initial release
// ============================================================================
module expr_buf
    import expr_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int AW      = 4
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_ptr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_ptr,
    output logic [7:0]    rd_data
);

    logic [7:0] r_mem [MAX_LEN];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/expr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : expr_arbiter
// Purpose  : Buffers '='-terminated expressions from two requesters and
//            streams them to a shared serial evaluator, reporting verdicts.
//            EXPR_ARB_RR_EN selects round-robin tie-break (else A priority).
// Revision : 1.0 - initial release
// ============================================================================
module expr_arbiter
    import expr_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int RES_LAT = 2
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       a_valid,
    input  logic [7:0] a_char,
    output logic       a_ready,
    input  logic       b_valid,
    input  logic [7:0] b_char,
    output logic       b_ready,
    output logic       ev_clr,
    output logic [7:0] ev_in,
    input  logic       ev_out,
    input  logic [7:0] ev_res,
    output logic       done,
    output logic       done_id,
    output logic       done_ok,
    output logic       done_err,
    output logic [7:0] done_res,
    output logic       busy
);

    localparam int c_PW = $clog2(MAX_LEN + 1);
    localparam int c_AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int c_CW = (RES_LAT > 1) ? $clog2(RES_LAT) : 1;
    localparam logic [c_PW-1:0] c_MAX   = c_PW'(MAX_LEN);
    localparam logic [c_CW-1:0] c_WLAST = c_CW'(RES_LAT - 1);

    state_t          r_state;
    logic            r_grant;
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_wcnt;
    logic            r_ok;
    logic            r_a_ready;
    logic            r_b_ready;
    logic            r_done;
    logic            r_done_id;
    logic            r_done_ok;
    logic            r_done_err;
    logic [7:0]      r_done_res;

    logic            w_tie_pick;
    logic            w_pick;
    logic            w_xfer;
    logic [7:0]      w_char;
    logic            w_is_eq;
    logic            w_wr_en;
    logic            w_wait_ok;
    logic [7:0]      w_rd_data;

`ifdef EXPR_ARB_RR_EN
    logic            r_last_grant;
    assign w_tie_pick = ~r_last_grant;
`else
    assign w_tie_pick = ID_A;
`endif

    assign w_pick    = (a_valid && b_valid) ? w_tie_pick : (a_valid ? ID_A : ID_B);
    assign w_xfer    = (r_grant == ID_A) ? (a_valid && r_a_ready) : (b_valid && r_b_ready);
    assign w_char    = (r_grant == ID_A) ? a_char : b_char;
    assign w_is_eq   = (w_char == CH_EQ);
    assign w_wr_en   = (r_state == ST_LOAD) && w_xfer && !w_is_eq && (r_wr_ptr != c_MAX);
    // With RES_LAT==1 the first WAIT cycle is also the last, so use ev_out directly.
    assign w_wait_ok = (r_wcnt == '0) ? ev_out : r_ok;

    expr_buf #(
        .MAX_LEN (MAX_LEN),
        .AW      (c_AW)
    ) u_buf (
        .clk     (clk),
        .wr_en   (w_wr_en),
        .wr_ptr  (r_wr_ptr[c_AW-1:0]),
        .wr_data (w_char),
        .rd_ptr  (r_rd_ptr[c_AW-1:0]),
        .rd_data (w_rd_data)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state    <= ST_IDLE;
            r_grant    <= ID_B;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_wcnt     <= '0;
            r_ok       <= 1'b0;
            r_a_ready  <= 1'b0;
            r_b_ready  <= 1'b0;
            r_done     <= 1'b0;
            r_done_id  <= 1'b0;
            r_done_ok  <= 1'b0;
            r_done_err <= 1'b0;
            r_done_res <= CH_ZERO;
`ifdef EXPR_ARB_RR_EN
            r_last_grant <= ID_B;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (a_valid || b_valid) begin
                        r_grant   <= w_pick;
                        r_a_ready <= (w_pick == ID_A);
                        r_b_ready <= (w_pick == ID_B);
                        r_state   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (w_xfer) begin
                        if (w_is_eq) begin
                            r_a_ready <= 1'b0;
                            r_b_ready <= 1'b0;
                            if (r_wr_ptr != '0) begin
                                r_state <= ST_STREAM;
                            end else begin
                                r_done     <= 1'b1;
                                r_done_id  <= r_grant;
                                r_done_ok  <= 1'b0;
                                r_done_err <= 1'b0;
                                r_done_res <= CH_ZERO;
                                r_state    <= ST_REPORT;
                            end
                        end else if (r_wr_ptr == c_MAX) begin
                            r_state <= ST_DRAIN;
                        end else begin
                            r_wr_ptr <= r_wr_ptr + c_PW'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_xfer && w_is_eq) begin
                        r_a_ready  <= 1'b0;
                        r_b_ready  <= 1'b0;
                        r_done     <= 1'b1;
                        r_done_id  <= r_grant;
                        r_done_ok  <= 1'b0;
                        r_done_err <= 1'b1;
                        r_done_res <= CH_ZERO;
                        r_state    <= ST_REPORT;
                    end
                end
                ST_STREAM: begin
                    r_rd_ptr <= r_rd_ptr + c_PW'(1);
                    if (r_rd_ptr + c_PW'(1) == r_wr_ptr) begin
                        r_wcnt  <= '0;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_wcnt <= r_wcnt + c_CW'(1);
                    if (r_wcnt == '0) begin
                        r_ok <= ev_out;
                    end
                    if (r_wcnt == c_WLAST) begin
                        r_done     <= 1'b1;
                        r_done_id  <= r_grant;
                        r_done_ok  <= w_wait_ok;
                        r_done_err <= 1'b0;
                        r_done_res <= w_wait_ok ? ev_res : CH_ZERO;
                        r_state    <= ST_REPORT;
                    end
                end
                ST_REPORT: begin
`ifdef EXPR_ARB_RR_EN
                    r_last_grant <= r_grant;
`endif
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign a_ready  = r_a_ready;
    assign b_ready  = r_b_ready;
    assign ev_clr   = !((r_state == ST_STREAM) || (r_state == ST_WAIT));
    assign ev_in    = (r_state == ST_STREAM) ? w_rd_data : CH_SP;
    assign done     = r_done;
    assign done_id  = r_done_id;
    assign done_ok  = r_done_ok;
    assign done_err = r_done_err;
    assign done_res = r_done_res;
    assign busy     = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_expr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_expr_arbiter
// Purpose  : Scoreboard bench for expr_arbiter with a behavioural evaluator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_expr_arbiter;

    localparam int MAX_LEN = 4;
    localparam int RES_LAT = 2;

    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic       a_valid = 1'b0;
    logic [7:0] a_char = 8'h00;
    logic       a_ready;
    logic       b_valid = 1'b0;
    logic [7:0] b_char = 8'h00;
    logic       b_ready;
    logic       ev_clr;
    logic [7:0] ev_in;
    logic       ev_out;
    logic [7:0] ev_res;
    logic       done, done_id, done_ok, done_err, busy;
    logic [7:0] done_res;

    expr_arbiter #(.MAX_LEN(MAX_LEN), .RES_LAT(RES_LAT)) dut (
        .clk(clk), .clr_n(clr_n),
        .a_valid(a_valid), .a_char(a_char), .a_ready(a_ready),
        .b_valid(b_valid), .b_char(b_char), .b_ready(b_ready),
        .ev_clr(ev_clr), .ev_in(ev_in), .ev_out(ev_out), .ev_res(ev_res),
        .done(done), .done_id(done_id), .done_ok(done_ok), .done_err(done_err),
        .done_res(done_res), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Serial evaluator: single digits joined by + and *, result mod 10 in ASCII.
    logic [7:0] m_sum, m_prod;
    logic       m_expd, m_bad;
    always @(posedge clk) begin : eval_model
        logic [7:0] s, p;
        logic       e, b;
        if (ev_clr) begin
            m_sum <= 8'd0; m_prod <= 8'd1; m_expd <= 1'b1; m_bad <= 1'b0;
            ev_out <= 1'b0; ev_res <= 8'h30;
        end else if (ev_in != 8'h20) begin
            s = m_sum; p = m_prod; e = m_expd; b = m_bad;
            if (ev_in >= 8'h30 && ev_in <= 8'h39) begin
                if (!e) b = 1'b1;
                p = p * (ev_in - 8'h30);
                e = 1'b0;
            end else if (ev_in == 8'h2B) begin
                if (e) b = 1'b1;
                s = s + p; p = 8'd1; e = 1'b1;
            end else if (ev_in == 8'h2A) begin
                if (e) b = 1'b1;
                e = 1'b1;
            end else begin
                b = 1'b1;
            end
            m_sum <= s; m_prod <= p; m_expd <= e; m_bad <= b;
            ev_out <= !b && !e;
            ev_res <= 8'h30 + ((s + p) % 8'd10);
        end
    end

    typedef struct {
        logic       id;
        logic       ok;
        logic       err;
        logic [7:0] res;
        int         len;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] str_q[$];
    int         n_chk = 0;
    int         n_err = 0;
    int         last_str_cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        n_chk++;
        n_err++;
        $display("FAIL %s (t=%0t)", nm, $time);
    endtask

    // Pushes the stream characters and, if with_done, the final verdict.
    task automatic expect_expr(input logic id, input string s, input logic ok,
                               input logic [7:0] res, input bit with_done);
        exp_t e;
        int   n = 0;
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == 8'h3D) break;
            n++;
        end
        e.id  = id;
        e.err = (n > MAX_LEN);
        e.ok  = e.err ? 1'b0 : ok;
        e.res = e.ok ? res : 8'h30;
        e.len = e.err ? 0 : n;
        if (!e.err) for (int i = 0; i < n; i++) str_q.push_back(s[i]);
        if (with_done) exp_q.push_back(e);
    endtask

    task automatic send(input logic id, input string s);
        for (int i = 0; i < s.len(); i++) begin
            int n = 0;
            @(negedge clk);
            if (id) begin b_valid = 1'b1; b_char = s[i]; end
            else    begin a_valid = 1'b1; a_char = s[i]; end
            while (!(id ? b_ready : a_ready)) begin
                @(negedge clk);
                n++;
                if (n > 200) begin
                    fail_now("ready_timeout");
                    a_valid = 1'b0; b_valid = 1'b0;
                    return;
                end
            end
        end
        @(negedge clk);
        if (id) b_valid = 1'b0; else a_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            fail_now("idle_timeout");
            exp_q.delete();
            str_q.delete();
        end
        @(negedge clk);
    endtask

    // Monitor: compares streamed characters and done verdicts against the queues.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (clr_n) begin
                if (!ev_clr && ev_in != 8'h20) begin
                    if (str_q.size() == 0) fail_now("stream_unexpected");
                    else begin
                        chk("stream_char", ev_in, str_q.pop_front());
                        last_str_cyc = cyc;
                    end
                end
                if (done) begin
                    if (exp_q.size() == 0) fail_now("done_unexpected");
                    else begin
                        e = exp_q.pop_front();
                        chk("done_id",  done_id,  e.id);
                        chk("done_ok",  done_ok,  e.ok);
                        chk("done_err", done_err, e.err);
                        chk("done_res", done_res, e.res);
                        if (e.len > 0) chk("done_latency", cyc - last_str_cyc, RES_LAT + 1);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin : stim
        #12;
        chk("rst_ev_clr",   ev_clr,   1);
        chk("rst_ev_in",    ev_in,    8'h20);
        chk("rst_busy",     busy,     0);
        chk("rst_a_ready",  a_ready,  0);
        chk("rst_b_ready",  b_ready,  0);
        chk("rst_done",     done,     0);
        chk("rst_done_ok",  done_ok,  0);
        chk("rst_done_err", done_err, 0);
        chk("rst_done_id",  done_id,  0);
        chk("rst_done_res", done_res, 8'h30);
        @(posedge clk); #2;
        clr_n = 1'b1;

        // Tie straight after reset: A first in both arbitration modes.
        expect_expr(0, "3=", 1, "3", 1);
        expect_expr(1, "4*5=", 1, "0", 1);
        fork
            send(0, "3=");
            send(1, "4*5=");
        join
        wait_idle();

        expect_expr(0, "1+2=", 1, "3", 1);
        send(0, "1+2=");
        wait_idle();

        // Tie after A was last served.
`ifdef EXPR_ARB_RR_EN
        expect_expr(1, "2=", 1, "2", 1);
        expect_expr(0, "1=", 1, "1", 1);
`else
        expect_expr(0, "1=", 1, "1", 1);
        expect_expr(1, "2=", 1, "2", 1);
`endif
        fork
            send(0, "1=");
            send(1, "2=");
        join
        wait_idle();

        // Reset in the middle of streaming aborts without a done pulse.
        expect_expr(0, "9*9=", 1, "1", 0);
        send(0, "9*9=");
        @(posedge clk); #2;
        clr_n = 1'b0;
        #1;
        chk("abort_ev_clr",   ev_clr,   1);
        chk("abort_busy",     busy,     0);
        chk("abort_a_ready",  a_ready,  0);
        chk("abort_b_ready",  b_ready,  0);
        chk("abort_ev_in",    ev_in,    8'h20);
        chk("abort_done_ok",  done_ok,  0);
        chk("abort_done_res", done_res, 8'h30);
        str_q.delete();
        @(posedge clk); #2;
        clr_n = 1'b1;
        expect_expr(0, "7=", 1, "7", 1);
        send(0, "7=");
        wait_idle();

        expect_expr(0, "1+=", 0, 8'h30, 1);
        send(0, "1+=");
        wait_idle();

        expect_expr(1, "=", 0, 8'h30, 1);
        send(1, "=");
        wait_idle();

        expect_expr(0, "1+2+=", 0, 8'h30, 1);
        send(0, "1+2+=");
        wait_idle();

        expect_expr(0, "1+2+3=", 0, 8'h30, 1);
        send(0, "1+2+3=");
        wait_idle();

        repeat (3) @(negedge clk);
        if (str_q.size() != 0) fail_now("stream_leftover");
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
